// File: rtl/ulpi_link_ctrl.sv
// ulpi_link_ctrl: link-side ULPI controller.
// Splits the tri-state data bus into in/out/oe, manages bus turnaround,
// sends upstream packets to the PHY (first byte is the TX CMD), and
// passes received data and RX CMD bytes to the packet layer.
module ulpi_link_ctrl #(
    parameter logic [7:0] STOP_ERR = 8'hFF,
    parameter logic [7:0] STOP_OK  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic       ulpi_stp,
    input  logic [7:0] ulpi_data_in,
    output logic [7:0] ulpi_data_out,
    output logic       ulpi_data_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_abort,
    output logic       tx_error,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_cmd_valid,
    output logic [7:0] rx_cmd
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX,
        ST_STOP,
        ST_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic       dir_q, dir_d;
    logic       drive_q, drive_d;
    logic [7:0] data_out_q, data_out_d;
    logic       stp_q, stp_d;
    logic       last_q, last_d;
    logic       tx_abort_q, tx_abort_d;
    logic       tx_error_q, tx_error_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_cmd_valid_q, rx_cmd_valid_d;
    logic [7:0] rx_cmd_q, rx_cmd_d;
    logic       tx_ready_c;

    // Link owns the bus only when the PHY has not claimed it for two cycles;
    // the PHY data is valid only when it has held the bus for two cycles.
    // Any cycle where dir differs from dir_q is a turnaround and is ignored.
    logic bus_ours;
    logic phy_rx;

    assign bus_ours = ~ulpi_dir & ~dir_q;
    assign phy_rx   = ulpi_dir & dir_q;

    // Drive enable drops combinationally with dir so the bus is released
    // in the very cycle the PHY turns it around.
    assign ulpi_data_oe  = drive_q & ~ulpi_dir & ~dir_q;
    assign ulpi_data_out = data_out_q;
    assign ulpi_stp      = stp_q;
    assign tx_ready      = tx_ready_c;
    assign tx_abort      = tx_abort_q;
    assign tx_error      = tx_error_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_cmd_valid  = rx_cmd_valid_q;
    assign rx_cmd        = rx_cmd_q;

    // Next-state and output logic for the transmit state machine.
    always_comb begin
        state_d    = state_q;
        drive_d    = drive_q;
        data_out_d = data_out_q;
        stp_d      = 1'b0;
        last_d     = last_q;
        tx_abort_d = 1'b0;
        tx_error_d = 1'b0;
        tx_ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_ready_c = tx_valid & bus_ours;
                if (tx_ready_c) begin
                    data_out_d = tx_data;
                    last_d     = tx_last;
                    drive_d    = 1'b1;
                    state_d    = ST_TX;
                end
            end
            ST_TX: begin
                // dir wins over nxt: a byte offered while the PHY grabs the
                // bus is lost and the packet is abandoned.
                if (ulpi_dir) begin
                    tx_abort_d = 1'b1;
                    drive_d    = 1'b0;
                    state_d    = ST_WAIT;
                end else if (ulpi_nxt) begin
                    if (last_q) begin
                        stp_d      = 1'b1;
                        data_out_d = STOP_OK;
                        state_d    = ST_STOP;
                    end else if (tx_valid) begin
                        tx_ready_c = 1'b1;
                        data_out_d = tx_data;
                        last_d     = tx_last;
                    end else begin
                        // Upstream ran dry mid-packet: terminate with an
                        // error stop so the PHY discards the packet.
                        stp_d      = 1'b1;
                        data_out_d = STOP_ERR;
                        tx_error_d = 1'b1;
                        state_d    = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                drive_d    = 1'b0;
                data_out_d = 8'h00;
                state_d    = ulpi_dir ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (bus_ours) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                drive_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Receive path: classify each owned PHY cycle as data or RX CMD.
    always_comb begin
        dir_d          = ulpi_dir;
        rx_valid_d     = phy_rx & ulpi_nxt;
        rx_cmd_valid_d = phy_rx & ~ulpi_nxt;
        rx_data_d      = rx_data_q;
        rx_cmd_d       = rx_cmd_q;
        if (phy_rx & ulpi_nxt) begin
            rx_data_d = ulpi_data_in;
        end
        if (phy_rx & ~ulpi_nxt) begin
            rx_cmd_d = ulpi_data_in;
        end
    end

    // State and output registers; reset parks the link with stp raised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            dir_q          <= 1'b1;
            drive_q        <= 1'b0;
            data_out_q     <= 8'h00;
            stp_q          <= 1'b1;
            last_q         <= 1'b0;
            tx_abort_q     <= 1'b0;
            tx_error_q     <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= 8'h00;
            rx_cmd_valid_q <= 1'b0;
            rx_cmd_q       <= 8'h00;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            drive_q        <= drive_d;
            data_out_q     <= data_out_d;
            stp_q          <= stp_d;
            last_q         <= last_d;
            tx_abort_q     <= tx_abort_d;
            tx_error_q     <= tx_error_d;
            rx_valid_q     <= rx_valid_d;
            rx_data_q      <= rx_data_d;
            rx_cmd_valid_q <= rx_cmd_valid_d;
            rx_cmd_q       <= rx_cmd_d;
        end
    end

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// tb_ulpi_link_ctrl: randomized packet-level bench for ulpi_link_ctrl.
// A PHY model observes what the link puts on the bus and a packet-level
// model predicts bytes delivered, stop values, pulses and RX output.
module tb_ulpi_link_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic       ulpi_stp;
    logic [7:0] ulpi_data_in;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_abort;
    logic       tx_error;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_cmd_valid;
    logic [7:0] rx_cmd;

    always #5 clk = ~clk;

    ulpi_link_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ulpi_dir     (ulpi_dir),
        .ulpi_nxt     (ulpi_nxt),
        .ulpi_stp     (ulpi_stp),
        .ulpi_data_in (ulpi_data_in),
        .ulpi_data_out(ulpi_data_out),
        .ulpi_data_oe (ulpi_data_oe),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .tx_abort     (tx_abort),
        .tx_error     (tx_error),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_cmd_valid (rx_cmd_valid),
        .rx_cmd       (rx_cmd)
    );

    typedef struct {
        bit         is_data;
        logic [7:0] data;
        int         stamp;
    } rx_ev_t;

    logic [8:0] up_q[$];
    logic [7:0] phy_seen[$];
    logic [7:0] stop_vals[$];
    rx_ev_t     rx_exp[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic dir_prev = 1'b1;
    int   cnt_ready, cnt_abort, cnt_error, bad_oe, bad_ready, bad_rx;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic refresh_up();
        if (up_q.size() > 0) begin
            tx_valid = 1'b1;
            tx_last  = up_q[0][8];
            tx_data  = up_q[0][7:0];
        end else begin
            tx_valid = 1'b0;
            tx_last  = 1'b0;
            tx_data  = 8'h00;
        end
    endtask

    // One clock: observe at negedge, advance the upstream queue after posedge.
    task automatic tick();
        logic   hs;
        rx_ev_t e;
        @(negedge clk);
        if (ulpi_data_oe && (ulpi_dir || dir_prev)) bad_oe++;
        if (ulpi_data_oe && ulpi_nxt && !ulpi_stp) phy_seen.push_back(ulpi_data_out);
        if (ulpi_stp) stop_vals.push_back(ulpi_data_out);
        hs = tx_valid & tx_ready;
        if (hs) begin
            cnt_ready++;
            if (ulpi_dir || dir_prev) bad_ready++;
        end
        if (tx_abort) cnt_abort++;
        if (tx_error) cnt_error++;
        if (rx_valid && rx_cmd_valid) bad_rx++;
        if (rx_valid || rx_cmd_valid) begin
            if (rx_exp.size() == 0) begin
                check_val("rx_unexpected", 32'(rx_valid | rx_cmd_valid), 32'd0);
            end else begin
                e = rx_exp.pop_front();
                check_val("rx_kind", 32'(rx_valid), 32'(e.is_data));
                check_val("rx_byte", 32'(rx_valid ? rx_data : rx_cmd), 32'(e.data));
                check_val("rx_latency", cyc, e.stamp + 1);
            end
        end
        // A PHY-owned cycle that is not a turnaround yields one RX item.
        if (ulpi_dir && dir_prev) begin
            e.is_data = ulpi_nxt;
            e.data    = ulpi_data_in;
            e.stamp   = cyc;
            rx_exp.push_back(e);
        end
        @(posedge clk);
        #1;
        dir_prev = ulpi_dir;
        cyc++;
        if (hs) void'(up_q.pop_front());
        refresh_up();
    endtask

    task automatic rx_burst(input int n);
        for (int i = 0; i < n; i++) begin
            ulpi_dir     = 1'b1;
            ulpi_nxt     = ($urandom_range(0, 1) == 1);
            ulpi_data_in = 8'($urandom);
            tick();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ulpi_dir     = 1'b0;
            ulpi_nxt     = 1'b0;
            ulpi_data_in = 8'h00;
            tick();
        end
    endtask

    // mode 0 normal, 1 underrun, 2 PHY takeover mid-packet,
    // 3 PHY takeover during the stop cycle, 4 packet queued during RX.
    task automatic scen(input int mode, input bit fixed);
        int         len, k;
        logic [7:0] bytes[$];
        logic       l;
        bit         raised, done;
        int         exp_taken, exp_ready, exp_abort, exp_error, exp_stops;
        logic [7:0] exp_stop;

        phy_seen.delete();
        stop_vals.delete();
        cnt_ready = 0; cnt_abort = 0; cnt_error = 0;
        bad_oe = 0; bad_ready = 0; bad_rx = 0;
        k = 0;
        if (mode == 1)      len = $urandom_range(1, 4);
        else if (mode == 2) len = $urandom_range(2, 5);
        else                len = fixed ? 3 : $urandom_range(1, 5);
        if (mode == 2) k = $urandom_range(0, len - 1);
        for (int i = 0; i < len; i++) begin
            if (fixed) bytes.push_back((i == 0) ? 8'h43 : (i == 1) ? 8'hA5 : 8'h5A);
            else       bytes.push_back(8'($urandom));
            l = (mode != 1) && (i == len - 1);
            up_q.push_back({l, bytes[i]});
        end

        if (mode == 4) begin
            ulpi_dir = 1'b1;
            refresh_up();
            rx_burst($urandom_range(2, 6));
        end else begin
            refresh_up();
        end

        raised = 0;
        done   = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            if (mode == 2 && phy_seen.size() == k && ulpi_data_oe && !ulpi_stp) raised = 1;
            if (mode == 3 && ulpi_stp) raised = 1;
            if (raised) begin
                ulpi_dir     = 1'b1;
                ulpi_nxt     = ($urandom_range(0, 1) == 1);
                ulpi_data_in = 8'($urandom);
                if (mode == 2) up_q.delete();
                refresh_up();
                #1;
                check_val("oe_release", 32'(ulpi_data_oe), 32'd0);
                tick();
                done = 1;
            end else begin
                ulpi_dir     = 1'b0;
                ulpi_nxt     = ($urandom_range(0, 2) != 0);
                ulpi_data_in = 8'h00;
                tick();
                done = (mode != 2) && (mode != 3) && (stop_vals.size() > 0);
            end
        end
        check_val("scenario_done", 32'(done), 32'd1);
        if (mode == 2 || mode == 3) rx_burst($urandom_range(1, 5));
        idle(4);

        exp_taken = (mode == 2) ? k : len;
        exp_ready = (mode == 2) ? k + 1 : len;
        exp_abort = (mode == 2) ? 1 : 0;
        exp_error = (mode == 1) ? 1 : 0;
        exp_stops = (mode == 2) ? 0 : 1;
        exp_stop  = (mode == 1) ? 8'hFF : 8'h00;

        check_val("tx_count", phy_seen.size(), exp_taken);
        for (int i = 0; i < exp_taken && i < phy_seen.size(); i++)
            check_val($sformatf("tx_byte%0d", i), 32'(phy_seen[i]), 32'(bytes[i]));
        check_val("stop_count", stop_vals.size(), exp_stops);
        if (stop_vals.size() > 0) check_val("stop_value", 32'(stop_vals[0]), 32'(exp_stop));
        check_val("ready_count", cnt_ready, exp_ready);
        check_val("abort_count", cnt_abort, exp_abort);
        check_val("error_count", cnt_error, exp_error);
        check_val("oe_while_phy", bad_oe, 0);
        check_val("ready_while_phy", bad_ready, 0);
        check_val("rx_both_valid", bad_rx, 0);
        check_val("rx_pending", rx_exp.size(), 0);
        check_val("upstream_left", up_q.size(), 0);
        check_val("idle_oe", 32'(ulpi_data_oe), 32'd0);
        check_val("idle_stp", 32'(ulpi_stp), 32'd0);
        $display("scenario mode=%0d len=%0d k=%0d taken=%0d stops=%0d ready=%0d abort=%0d error=%0d",
                 mode, len, k, phy_seen.size(), stop_vals.size(), cnt_ready, cnt_abort, cnt_error);
    endtask

    initial begin
        reset        = 1'b1;
        ulpi_dir     = 1'b0;
        ulpi_nxt     = 1'b0;
        ulpi_data_in = 8'h00;
        tx_valid     = 1'b1;
        tx_data      = 8'h43;
        tx_last      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_stp", 32'(ulpi_stp), 32'd1);
        check_val("rst_oe", 32'(ulpi_data_oe), 32'd0);
        check_val("rst_ready", 32'(tx_ready), 32'd0);
        check_val("rst_pulses", 32'({tx_abort, tx_error, rx_valid, rx_cmd_valid}), 32'd0);
        check_val("rst_data_out", 32'(ulpi_data_out), 32'd0);
        refresh_up();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        dir_prev = 1'b1;
        @(negedge clk);
        check_val("rel_stp_held", 32'(ulpi_stp), 32'd1);
        @(posedge clk);
        #1;
        dir_prev = ulpi_dir;
        check_val("rel_stp_cleared", 32'(ulpi_stp), 32'd0);
        check_val("rel_oe", 32'(ulpi_data_oe), 32'd0);

        scen(0, 1'b1);
        for (int m = 0; m < 5; m++) scen(m, 1'b0);
        for (int s = 0; s < 40; s++) scen($urandom_range(0, 4), 1'b0);

        // Reset in the middle of a packet returns everything to rest at once.
        up_q.push_back({1'b0, 8'h41});
        up_q.push_back({1'b1, 8'h99});
        refresh_up();
        ulpi_dir = 1'b0;
        ulpi_nxt = 1'b0;
        for (int c = 0; c < 10 && !ulpi_data_oe; c++) tick();
        check_val("mid_driving", 32'(ulpi_data_oe), 32'd1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_oe", 32'(ulpi_data_oe), 32'd0);
        check_val("mid_rst_stp", 32'(ulpi_stp), 32'd1);
        up_q.delete();
        refresh_up();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        dir_prev = 1'b1;
        idle(3);
        check_val("mid_after_stp", 32'(ulpi_stp), 32'd0);
        check_val("mid_after_oe", 32'(ulpi_data_oe), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ulpi_link_ctrl.md
Name: ulpi_link_ctrl

Overview:
- Link-side ULPI controller that drives the link modport signals of the ULPI interface: clk, dir, nxt, stp and the bidirectional 8-bit data bus.
- Splits the tri-state data bus into in/out/oe halves and manages bus turnaround.
- Transmits packets from an upstream byte stream (first byte is the ULPI TX CMD).
- Delivers received data bytes and RX CMD bytes to the downstream USB packet layer.

Parameters:
- STOP_ERR, 8'hFF, data value driven with stp when a TX underrun occurs (signals error/abort to the PHY).
- STOP_OK, 8'h00, data value driven with stp on normal end of packet.

Ports:
- clk  in  1  ULPI 60 MHz clock, all logic on posedge.
- reset  in  1  asynchronous, active-high.
- ulpi_dir  in  1  PHY owns bus when 1.
- ulpi_nxt  in  1  PHY throttle / data-vs-cmd qualifier.
- ulpi_stp  out  1  stop strobe to PHY.
- ulpi_data_in  in  8  bus sampled value.
- ulpi_data_out  out  8  bus drive value.
- ulpi_data_oe  out  1  bus drive enable (top level builds tri-state).
- tx_valid  in  1  upstream byte available.
- tx_data  in  8  upstream byte; first byte of a packet is the TX CMD.
- tx_last  in  1  marks final byte of packet.
- tx_ready  out  1  byte accepted this cycle (valid&ready handshake).
- tx_abort  out  1  one-cycle pulse: packet lost to PHY bus takeover.
- tx_error  out  1  one-cycle pulse: underrun, packet terminated with STOP_ERR.
- rx_valid  out  1  rx_data holds a received packet byte.
- rx_data  out  8  received byte.
- rx_cmd_valid  out  1  rx_cmd holds an RX CMD byte.
- rx_cmd  out  8  RX CMD byte (linestate, vbus, rxactive, rxerror).

Behaviour:
- Reset (async): ulpi_stp=1, ulpi_data_out=0, drive_q=0, all pulse/valid outputs 0, tx_ready=0, state=IDLE, dir_q=1. The first clock edge after reset release sets ulpi_stp=0.
- dir_q is ulpi_dir registered each cycle.
- Turnaround cycle: ulpi_dir!=dir_q. The bus is never sampled or driven in a turnaround cycle.
- ulpi_data_oe = drive_q & ~ulpi_dir & ~dir_q. This is combinational on ulpi_dir, so the bus is released in the same cycle the PHY raises dir.
- RX path: in cycles with ulpi_dir=1 and dir_q=1:
  - nxt=1: registered rx_valid=1, rx_data=ulpi_data_in.
  - nxt=0: registered rx_cmd_valid=1, rx_cmd=ulpi_data_in.
  - Latency is 1 cycle. The outputs are 1-cycle pulses and are mutually exclusive.
- TX state machine, states IDLE, TX, STOP, WAIT:
  - IDLE: tx_ready = tx_valid & ~ulpi_dir & ~dir_q.
    - On acceptance: ulpi_data_out<=tx_data, last_q<=tx_last, drive_q<=1, go to TX.
  - TX: data_out is held until the PHY takes it (ulpi_nxt=1 & ~ulpi_dir).
    - Byte taken and last_q=1: go to STOP; register ulpi_stp=1 and data_out=STOP_OK for the next cycle; tx_ready=0.
    - Byte taken, last_q=0, tx_valid=1: tx_ready=1; load the next byte and last_q in the same cycle; stay in TX.
    - Byte taken, last_q=0, tx_valid=0 (underrun): go to STOP with data_out=STOP_ERR, ulpi_stp=1, tx_error pulse.
    - The TX CMD byte follows the same rules; the PHY asserts nxt when it accepts the CMD.
  - STOP: one cycle with ulpi_stp=1 driving the stop value. Next cycle: ulpi_stp=0, drive_q=0, go to IDLE.
  - dir=1 seen in TX (before the final byte is taken):
    - tx_abort pulse; the held byte is discarded; drive_q=0; go to WAIT.
    - Upstream flushes/retries; the next accepted byte is a new TX CMD.
  - dir=1 seen in STOP: the stop has already been issued; go to WAIT with no abort.
  - WAIT: tx_ready=0. Exit to IDLE on the first cycle with ulpi_dir=0 & dir_q=0.
- Simultaneous nxt=1 and dir rising: dir wins. The byte counts as not taken and abort occurs.
- Reset mid-packet: immediate return to reset values. Upstream must restart the packet.
- ulpi_stp is driven only in STOP (and during reset). The link never aborts PHY RX.

Test Plan:
- Reset release: ulpi_stp=1 during reset, 0 on the 1st edge after; oe=0, no pulses.
- TX 3-byte packet 0x43,0xA5,0x5A with nxt high one cycle after each drive:
  - bus shows 43,A5,5A, then stp=1 with 0x00, then oe=0;
  - exactly 3 tx_ready pulses, no abort/error.
- Underrun: tx_valid drops after 0x43 is taken (last=0) -> stp=1 with data 0xFF, tx_error pulses once, return to IDLE.
- PHY takeover: dir rises while holding 0xA5 -> oe falls in the same cycle, tx_abort pulses once, no stp, WAIT until dir low for 2 cycles.
- RX sequence with dir=1 (turnaround, then nxt=0 0x4D, nxt=1 0xC3, nxt=1 0x11, nxt=0 0x4C):
  - turnaround byte ignored;
  - rx_cmd 0x4D, rx_data C3 and 11, rx_cmd 0x4C, each 1 cycle later;
  - oe=0 throughout.
- tx_valid asserted during RX or turnaround cycles -> tx_ready stays 0. The first byte is accepted only once dir=0 and dir_q=0.
